// File: rtl/regfile_pkg.sv
// Shared constants, typedefs and the bypass-winner helper for the register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // Upper bound on write ports that the bypass helper can arbitrate.
    localparam int MAX_WR = 8;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    // Index of the highest-numbered write port hitting a read address, or -1 if none.
    function automatic int bypass_winner(input logic [MAX_WR-1:0] hits);
        bypass_winner = -1;
        for (int i = 0; i < MAX_WR; i++) begin
            if (hits[i]) bypass_winner = i;
        end
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between decode/issue/writeback and the scoreboarded register file.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NWR-1:0]            wr_en;
    logic [NWR-1:0][AW-1:0]    wr_addr;
    logic [NWR-1:0][XLEN-1:0]  wr_data;
    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic [NRD-1:0][XLEN-1:0]  rd_data;
    logic [NRD-1:0]            rd_busy;
    logic                      iss_en;
    logic [AW-1:0]             iss_rd;
    logic                      flush;
    logic [AW:0]               busy_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_rd, flush,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_rd, flush,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, flush clears all,
// with a registered popcount of outstanding producers.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NWR-1:0]         wr_en_i,
    input  logic [NWR-1:0][AW-1:0] wr_addr_i,
    input  logic                   iss_en_i,
    input  logic [AW-1:0]          iss_rd_i,
    input  logic                   flush_i,
    output logic [NREGS-1:0]       busy_o,
    output logic [AW:0]            busy_cnt_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;

    // Next busy vector: flush/writeback clear first, then a new issue sets (the
    // newest producer is still outstanding), x0 never busy.
    always_comb begin
        busy_d = flush_i ? '0 : busy_q;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en_i[p]) busy_d[wr_addr_i[p]] = 1'b0;
        end
        if (iss_en_i && (iss_rd_i != '0)) busy_d[iss_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
        cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    // Busy bits and their count advance together on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with hardwired x0, optional same-cycle
// write-to-read bypass and a busy scoreboard for hazard detection.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,   // must not exceed MAX_WR
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_sb_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy;

    // Storage: ports applied in ascending order so the highest index wins; x0 never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (bus.wr_en[p] && (bus.wr_addr[p] != '0)) begin
                    regs_q[bus.wr_addr[p]] <= bus.wr_data[p];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (bus.wr_en),
        .wr_addr_i  (bus.wr_addr),
        .iss_en_i   (bus.iss_en),
        .iss_rd_i   (bus.iss_rd),
        .flush_i    (bus.flush),
        .busy_o     (busy),
        .busy_cnt_o (bus.busy_cnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [XLEN-1:0]   rd_val;
            logic              rd_bsy;
            logic [MAX_WR-1:0] hits;
            logic              iss_hit;
            int                win;

            // Read mux: stored value, overridden by the winning same-cycle write
            // when bypassing; x0 forced to zero. Busy is hidden while its
            // writeback is in flight unless a new producer issues to it.
            always_comb begin
                hits = '0;
                for (int p = 0; p < NWR; p++) begin
                    hits[p] = bus.wr_en[p] && (bus.wr_addr[p] == bus.rd_addr[gi]);
                end
                win    = bypass_winner(hits);
                rd_val = regs_q[bus.rd_addr[gi]];
                for (int p = 0; p < NWR; p++) begin
                    if ((BYPASS != 0) && (win == p)) rd_val = bus.wr_data[p];
                end
                if (bus.rd_addr[gi] == '0) rd_val = '0;
                iss_hit = bus.iss_en && (bus.iss_rd == bus.rd_addr[gi]);
                rd_bsy  = busy[bus.rd_addr[gi]];
                if ((BYPASS != 0) && (hits != '0) && !iss_hit) rd_bsy = 1'b0;
            end

            assign bus.rd_data[gi] = rd_val;
            assign bus.rd_busy[gi] = rd_bsy;
        end
    endgenerate

endmodule
